// File: rtl/lzc_seq_pkg.sv
// Shared types and constants for the lzc_seq leading-zero-count / normalize engine.
package lzc_seq_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_XLEN = 64;
  localparam int DEF_SLEN = 16;
  localparam int NCHUNK   = DEF_XLEN / DEF_SLEN;
endpackage

// File: rtl/lzc_seq_if.sv
// Request/result handshake bundle for lzc_seq: two requester ports and one result port.
interface lzc_seq_if #(
  parameter int XLEN = 64,
  parameter int XLOG = 6
);
  logic            a_valid;
  logic            a_ready;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [XLEN-1:0] b_data;
  logic            res_valid;
  logic            res_ready;
  logic            res_id;
  logic [XLOG:0]   res_count;
  logic            res_zero;
  logic [XLEN-1:0] res_norm;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, res_ready,
    output a_ready, b_ready, res_valid, res_id, res_count, res_zero, res_norm
  );
  modport master (
    output a_valid, a_data, b_valid, b_data, res_ready,
    input  a_ready, b_ready, res_valid, res_id, res_count, res_zero, res_norm
  );
endinterface

// File: rtl/lzc_16.sv
// 16-bit leading-one locator: o_v = any bit set, o_c = index of the highest set bit.
module lzc_16 (
  input  logic [15:0] i_d,
  output logic        o_v,
  output logic [3:0]  o_c
);
  always_comb begin
    o_c = '0;
    // Later iterations overwrite earlier ones, so the highest set bit wins.
    for (int i = 0; i < 16; i++)
      if (i_d[i]) o_c = 4'(i);
  end

  assign o_v = |i_d;
endmodule

// File: rtl/lzc_seq.sv
// Multi-cycle LZC + normalize shared by two requesters with round-robin arbitration.
// Optional LZC_SEQ_PERF_EN adds saturating perf_scan / perf_ops counters.
module lzc_seq
  import lzc_seq_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int SLEN = DEF_SLEN,
  parameter int XLOG = 6,
  parameter int SLOG = 4
) (
  input  logic        clock,
  input  logic        reset,
  lzc_seq_if.slave    bus
`ifdef LZC_SEQ_PERF_EN
  ,
  output logic [31:0] perf_scan,
  output logic [31:0] perf_ops
`endif
);
  localparam int NCHK = XLEN / SLEN;
  localparam logic [XLOG-1:0] KLAST = XLOG'(NCHK - 1);

  state_t          r_state;
  logic            r_ptr, r_id, r_zero, r_valid;
  logic [XLEN-1:0] r_data, r_scan, r_norm;
  logic [XLOG:0]   r_cnt;
  logic [XLOG-1:0] r_k;

  logic            w_idle, w_gnt_a, w_gnt_b, w_v;
  logic [SLOG-1:0] w_c, w_lz;

  assign w_idle  = (r_state == IDLE) && !reset;
  assign w_gnt_a = w_idle && bus.a_valid && (!bus.b_valid || r_ptr == REQ_A);
  assign w_gnt_b = w_idle && bus.b_valid && (!bus.a_valid || r_ptr == REQ_B);
  assign w_lz    = ~w_c;

  // r_scan is shifted up one chunk per empty step, so the lzc always sees its top chunk.
  lzc_16 u_lzc (
    .i_d (r_scan[XLEN-1 -: SLEN]),
    .o_v (w_v),
    .o_c (w_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= REQ_A;
      r_id    <= REQ_A;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_scan  <= '0;
      r_norm  <= '0;
      r_cnt   <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_a || w_gnt_b) begin
          r_data  <= w_gnt_a ? bus.a_data : bus.b_data;
          r_scan  <= w_gnt_a ? bus.a_data : bus.b_data;
          r_id    <= w_gnt_a ? REQ_A : REQ_B;
          r_ptr   <= w_gnt_a ? REQ_B : REQ_A;
          r_cnt   <= '0;
          r_k     <= '0;
          r_zero  <= 1'b0;
          r_state <= SCAN;
        end
        SCAN: if (w_v) begin
          r_cnt   <= r_cnt + {{(XLOG+1-SLOG){1'b0}}, w_lz};
          r_state <= SHIFT;
        end else if (r_k == KLAST) begin
          r_cnt   <= (XLOG+1)'(XLEN);
          r_zero  <= 1'b1;
          r_state <= SHIFT;
        end else begin
          r_cnt   <= r_cnt + (XLOG+1)'(SLEN);
          r_k     <= r_k + 1'b1;
          r_scan  <= r_scan << SLEN;
        end
        SHIFT: begin
          r_norm  <= r_data << r_cnt;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: if (bus.res_ready) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.a_ready   = w_gnt_a;
  assign bus.b_ready   = w_gnt_b;
  assign bus.res_valid = r_valid;
  assign bus.res_id    = r_id;
  assign bus.res_count = r_cnt;
  assign bus.res_zero  = r_zero;
  assign bus.res_norm  = r_norm;

`ifdef LZC_SEQ_PERF_EN
  logic [31:0] r_perf_scan, r_perf_ops;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_scan <= '0;
      r_perf_ops  <= '0;
    end else begin
      if (r_state == SCAN && r_perf_scan != '1) r_perf_scan <= r_perf_scan + 1'b1;
      if (r_valid && bus.res_ready && r_perf_ops != '1) r_perf_ops <= r_perf_ops + 1'b1;
    end
  end

  assign perf_scan = r_perf_scan;
  assign perf_ops  = r_perf_ops;
`endif
endmodule
